// File: rtl/signed_divider_seq_pkg.sv
// Shared types and constants for the sequential signed divider.
package signed_div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/signed_divider_seq_if.sv
// Start/done request and result bundle for signed_divider_seq.
interface signed_divider_seq_if #(
  parameter int unsigned WIDTH = signed_div_pkg::WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/signed_divider_seq_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = signed_div_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] div_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < div_mag <= 2^(WIDTH-1), so shifted < 2^WIDTH and diff[WIDTH] is the borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, div_mag};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: one quotient bit per clock, then a sign-fix cycle.
// Optional SIGNED_DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module signed_divider_seq
  import signed_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  signed_divider_seq_if.slave bus
);

  localparam int unsigned      CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0] iter;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic             dz_pend;
  logic             ov_pend;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;
  logic             dz_q;
  logic             ov_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             is_ovf;
  logic             early;
  logic             skip_calc;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (quo_mag[WIDTH-1]),
    .div_mag (div_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    a_abs  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_abs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    b_zero = (bus.divisor == '0);
    is_ovf = (bus.dividend == MIN_VAL) && (bus.divisor == '1);
`ifdef SIGNED_DIV_EARLY_OUT_EN
    early  = !b_zero && (a_abs < b_abs);
`else
    early  = 1'b0;
`endif
    skip_calc = b_zero | early;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = skip_calc ? FIX : CALC;
      CALC: if (iter == LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // quo_mag doubles as the dividend shift register: MSBs leave, quotient bits enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter        <= '0;
      quo_mag     <= '0;
      div_mag     <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r   <= bus.dividend[WIDTH-1];
            div_mag <= b_abs;
            iter    <= '0;
            dz_pend <= b_zero;
            ov_pend <= is_ovf;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            if (skip_calc) begin
              rem     <= a_abs;
              quo_mag <= '0;
            end else begin
              rem     <= '0;
              quo_mag <= a_abs;
            end
          end
        end
        CALC: begin
          quo_mag <= {quo_mag[WIDTH-2:0], step_q};
          rem     <= step_rem;
          iter    <= iter + CNT_W'(1);
        end
        FIX: begin
          quotient_q  <= dz_pend ? '1 : (neg_q ? -quo_mag : quo_mag);
          remainder_q <= neg_r ? -rem : rem;
          dz_q        <= dz_pend;
          ov_q        <= ov_pend;
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq with a latency/result reference model.
module tb_signed_divider_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  signed_divider_seq_if #(.WIDTH(W)) dut_if ();

  signed_divider_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mathematical result of a / b with the divider's flag rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (bi == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = W'(ai / bi);
      r  = W'(ai % bi);
      ov = (ai == -(2 ** (W - 1))) && (bi == -1);
    end
  endfunction

  // Edges from acceptance to the edge after which done is high.
  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return 1;
`ifdef SIGNED_DIV_EARLY_OUT_EN
    if ((ai < 0 ? -ai : ai) < (bi < 0 ? -bi : bi)) return 1;
`endif
    return W + 1;
  endfunction

  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_busy, m_done, m_dz, m_ov, p_dz, p_ov;
  int           remaining;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_q = '0; m_r = '0; m_dz = 0; m_ov = 0;
      remaining = 0;
    end else begin
      m_done = 0;
      if (remaining == 0) begin
        if (dut_if.start === 1'b1) begin
          model(dut_if.dividend, dut_if.divisor, p_q, p_r, p_dz, p_ov);
          remaining = latency(dut_if.dividend, dut_if.divisor);
          m_busy = 1; m_dz = 0; m_ov = 0;
        end
      end else begin
        remaining--;
        if (remaining == 0) begin
          m_busy = 0; m_done = 1;
          m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", dut_if.busy, m_busy);
    chk("done", dut_if.done, m_done);
    chk("quotient", dut_if.quotient, m_q);
    chk("remainder", dut_if.remainder, m_r);
    chk("div_by_zero", dut_if.div_by_zero, m_dz);
    chk("overflow", dut_if.overflow, m_ov);
  end

  // Entered at a negedge; leaves at the negedge where done is first seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int found;
    dut_if.start = 1'b1;
    dut_if.dividend = a;
    dut_if.divisor = b;
    @(negedge clk);
    dut_if.start = 1'b0;
    dut_if.dividend = W'($urandom);
    dut_if.divisor = W'($urandom);
    lat = -1;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dut_if.done === 1'b1) begin
        lat = k;
        found = 1;
        break;
      end
    end
    chk("done_seen", found, 1);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input logic ov);
    chk({tag, "_q"}, dut_if.quotient, q);
    chk({tag, "_r"}, dut_if.remainder, r);
    chk({tag, "_dz"}, dut_if.div_by_zero, dz);
    chk({tag, "_ov"}, dut_if.overflow, ov);
  endtask

  initial begin
    logic [W-1:0] mq, mr;
    logic         mdz, mov;
    logic [W-1:0] ra, rb;
    int           lat, seen;

    dut_if.start = 1'b0;
    dut_if.dividend = '0;
    dut_if.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", dut_if.busy, 0);
    chk("rst_done", dut_if.done, 0);
    chk_res("rst", 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    model(8'd100, 8'd7, mq, mr, mdz, mov);
    chk("model_100_7_q", mq, 8'd14);
    chk("model_100_7_r", mr, 8'd2);
    model(8'h9C, 8'd7, mq, mr, mdz, mov);
    chk("model_m100_7_q", mq, 8'hF2);
    chk("model_m100_7_r", mr, 8'hFE);
    model(8'h80, 8'hFF, mq, mr, mdz, mov);
    chk("model_ovf_q", mq, 8'h80);
    chk("model_ovf_flag", mov, 1'b1);
    model(8'd5, 8'd0, mq, mr, mdz, mov);
    chk("model_dz_q", mq, 8'hFF);
    chk("model_dz_flag", mdz, 1'b1);

    run_op(8'd100, 8'd7, lat);
    chk("lat_100_7", lat, 9);
    chk_res("d100_7", 8'd14, 8'd2, 1'b0, 1'b0);
    run_op(8'h9C, 8'd7, lat);
    chk_res("dm100_7", 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op(8'd100, 8'hF9, lat);
    chk_res("d100_m7", 8'hF2, 8'h02, 1'b0, 1'b0);
    run_op(8'h80, 8'hFF, lat);
    chk("lat_ovf", lat, 9);
    chk_res("dmin_m1", 8'h80, 8'h00, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, lat);
    chk_res("dmin_1", 8'h80, 8'h00, 1'b0, 1'b0);
    run_op(8'd5, 8'd0, lat);
    chk("lat_dz", lat, 1);
    chk_res("d5_0", 8'hFF, 8'h05, 1'b1, 1'b0);
    run_op(8'd3, 8'd9, lat);
`ifdef SIGNED_DIV_EARLY_OUT_EN
    chk("lat_3_9", lat, 1);
`else
    chk("lat_3_9", lat, 9);
`endif
    chk_res("d3_9", 8'h00, 8'h03, 1'b0, 1'b0);

    // start pulsed at edge 3 of a running division must be ignored
    dut_if.start = 1'b1; dut_if.dividend = 8'd100; dut_if.divisor = 8'd7;
    @(negedge clk);
    dut_if.start = 1'b0;
    repeat (2) @(negedge clk);
    dut_if.start = 1'b1; dut_if.dividend = 8'd3; dut_if.divisor = 8'd1;
    @(negedge clk);
    dut_if.start = 1'b0;
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      @(negedge clk);
      if (dut_if.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("lat_ignored_start", lat, 9);
    chk_res("ign", 8'd14, 8'd2, 1'b0, 1'b0);
    repeat (12) @(negedge clk);

    // reset shortly after edge 4 of a running division
    dut_if.start = 1'b1; dut_if.dividend = 8'd100; dut_if.divisor = 8'd7;
    @(negedge clk);
    dut_if.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", dut_if.busy, 0);
    chk("midrst_done", dut_if.done, 0);
    chk_res("midrst", 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dut_if.done === 1'b1) seen++;
    end
    chk("midrst_no_done", seen, 0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 8'd1;
        default: rb = W'($urandom);
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
      run_op(ra, rb, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
